// File: rtl/alu_ctrl.sv
// alu_ctrl: decodes RV32I instruction words into an ALU control word behind a
// valid/ready handshake with one cycle of latency.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   instr is valid this cycle
//   in_ready   block accepts instr this cycle
//   instr      RV32I instruction word
//   out_valid  decoded control word is valid
//   out_ready  downstream accepts the control word
//   sel_alu    ALU op (IN2, ADD, SUB, AND, OR, XOR, SHL, SHRL, SHRA, COMPU, COMPS)
//   asel       operand A source: 0 = rs1, 1 = pc
//   bsel       operand B source: 0 = rs2, 1 = imm
//   imm        decoded immediate
//   illegal    instruction not decodable to an ALU op
//
// Build option: define ALU_CTRL_SKID_EN for a 2-entry skid buffer with a
// registered in_ready; otherwise a single output register is used and
// in_ready is combinational (!out_valid || out_ready).
module alu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  sel_alu,
  output logic        asel,
  output logic        bsel,
  output logic [31:0] imm,
  output logic        illegal
);

  localparam logic [3:0] AluIn2  = 4'b0000;
  localparam logic [3:0] AluAdd  = 4'b0001;
  localparam logic [3:0] AluSub  = 4'b0010;
  localparam logic [3:0] AluAnd  = 4'b0011;
  localparam logic [3:0] AluOr   = 4'b0100;
  localparam logic [3:0] AluXor  = 4'b0101;
  localparam logic [3:0] AluShl  = 4'b0110;
  localparam logic [3:0] AluShrl = 4'b0111;
  localparam logic [3:0] AluShra = 4'b1000;
  localparam logic [3:0] AluCompu = 4'b1001;
  localparam logic [3:0] AluComps = 4'b1010;

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;
  localparam logic [6:0] OpcLoad  = 7'b0000011;
  localparam logic [6:0] OpcStore = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  typedef struct packed {
    logic [3:0]  sel;
    logic        asel;
    logic        bsel;
    logic [31:0] imm;
    logic        illegal;
  } ctl_t;

  // ---------------------------------------------------------------------------
  // Decoder
  // ---------------------------------------------------------------------------
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_u, imm_sh;
  logic [3:0]  f3_op;
  ctl_t        dec;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_sh = {27'b0, instr[24:20]};

  // Shared funct3 -> op mapping for OP and OP-IMM.
  always_comb begin
    f3_op = AluAdd;
    unique case (funct3)
      3'b000: f3_op = AluAdd;
      3'b001: f3_op = AluShl;
      3'b010: f3_op = AluComps;
      3'b011: f3_op = AluCompu;
      3'b100: f3_op = AluXor;
      3'b101: f3_op = AluShrl;
      3'b110: f3_op = AluOr;
      3'b111: f3_op = AluAnd;
      default: f3_op = AluAdd;
    endcase
  end

  always_comb begin
    dec         = '0;
    dec.illegal = 1'b1;
    unique case (opcode)
      OpcOp: begin
        if (funct7 == F7Base) begin
          dec.sel     = f3_op;
          dec.illegal = 1'b0;
        end else if (funct7 == F7Alt && funct3 == 3'b000) begin
          dec.sel     = AluSub;
          dec.illegal = 1'b0;
        end else if (funct7 == F7Alt && funct3 == 3'b101) begin
          dec.sel     = AluShra;
          dec.illegal = 1'b0;
        end
      end
      OpcOpImm: begin
        dec.bsel = 1'b1;
        if (funct3 == 3'b001) begin
          dec.sel     = AluShl;
          dec.imm     = imm_sh;
          dec.illegal = (funct7 != F7Base);
        end else if (funct3 == 3'b101) begin
          dec.sel     = (funct7 == F7Alt) ? AluShra : AluShrl;
          dec.imm     = imm_sh;
          dec.illegal = (funct7 != F7Base) && (funct7 != F7Alt);
        end else begin
          dec.sel     = f3_op;
          dec.imm     = imm_i;
          dec.illegal = 1'b0;
        end
      end
      OpcLui: begin
        dec.sel     = AluIn2;
        dec.bsel    = 1'b1;
        dec.imm     = imm_u;
        dec.illegal = 1'b0;
      end
      OpcAuipc: begin
        dec.sel     = AluAdd;
        dec.asel    = 1'b1;
        dec.bsel    = 1'b1;
        dec.imm     = imm_u;
        dec.illegal = 1'b0;
      end
      OpcLoad: begin
        dec.sel     = AluAdd;
        dec.bsel    = 1'b1;
        dec.imm     = imm_i;
        dec.illegal = 1'b0;
      end
      OpcStore: begin
        dec.sel     = AluAdd;
        dec.bsel    = 1'b1;
        dec.imm     = imm_s;
        dec.illegal = 1'b0;
      end
      OpcBranch: begin
        dec.illegal = 1'b0;
        case (funct3)
          3'b000, 3'b001: dec.sel = AluSub;
          3'b100, 3'b101: dec.sel = AluComps;
          3'b110, 3'b111: dec.sel = AluCompu;
          default:        dec.illegal = 1'b1;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
    // Illegal words present an all-zero control word.
    if (dec.illegal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output buffering
  // ---------------------------------------------------------------------------
  logic out_valid_q, out_valid_d;
  ctl_t out_q, out_d;
  logic in_fire;

`ifdef ALU_CTRL_SKID_EN
  logic skid_valid_q, skid_valid_d;
  ctl_t skid_q, skid_d;
  logic in_ready_q, in_ready_d;

  assign in_ready = in_ready_q;
  assign in_fire  = in_valid && in_ready_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (skid_valid_q) begin
      // Input is closed; drain the skid entry into the output when it moves.
      if (out_ready) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (out_valid_q && !out_ready) begin
      // Output stalled: one more word can be parked.
      if (in_fire) begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end
    end else if (in_fire) begin
      out_d       = dec;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      in_ready_q   <= in_ready_d;
    end
  end
`else
  assign in_ready = !out_valid_q || out_ready;
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (in_fire) begin
      out_d       = dec;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign sel_alu   = out_q.sel;
  assign asel      = out_q.asel;
  assign bsel      = out_q.bsel;
  assign imm       = out_q.imm;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: directed decode vectors, stall/ordering,
// reset behaviour and a randomized stream against a queue-based model.
module tb_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  sel_alu;
  logic        asel;
  logic        bsel;
  logic [31:0] imm;
  logic        illegal;

  alu_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_alu   (sel_alu),
    .asel      (asel),
    .bsel      (bsel),
    .imm       (imm),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  sel;
    logic        asel;
    logic        bsel;
    logic [31:0] imm;
    logic        illegal;
  } ctl_t;

  // funct3-indexed tables (element 0 first).
  localparam logic [3:0] OP_TAB [8] = '{4'd1, 4'd6, 4'd10, 4'd9, 4'd5, 4'd7, 4'd4, 4'd3};
  localparam logic [3:0] BR_TAB [8] = '{4'd2, 4'd2, 4'd0, 4'd0, 4'd10, 4'd10, 4'd9, 4'd9};

  ctl_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic ctl_t model(input logic [31:0] w);
    ctl_t c;
    logic ok;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = w[6:0];
    f3  = w[14:12];
    f7  = w[31:25];
    c   = '0;
    ok  = 1'b0;
    if (opc == 7'h33) begin
      if (f7 == 7'h00) begin c.sel = OP_TAB[f3]; ok = 1'b1; end
      else if (f7 == 7'h20 && f3 == 3'd0) begin c.sel = 4'd2; ok = 1'b1; end
      else if (f7 == 7'h20 && f3 == 3'd5) begin c.sel = 4'd8; ok = 1'b1; end
    end else if (opc == 7'h13) begin
      c.bsel = 1'b1;
      if (f3 == 3'd1 || f3 == 3'd5) begin
        c.imm = 32'(w[24:20]);
        if (f7 == 7'h00) begin c.sel = OP_TAB[f3]; ok = 1'b1; end
        else if (f7 == 7'h20 && f3 == 3'd5) begin c.sel = 4'd8; ok = 1'b1; end
      end else begin
        c.sel = OP_TAB[f3];
        c.imm = 32'($signed(w[31:20]));
        ok = 1'b1;
      end
    end else if (opc == 7'h37 || opc == 7'h17) begin
      c.sel  = (opc == 7'h37) ? 4'd0 : 4'd1;
      c.asel = (opc == 7'h17);
      c.bsel = 1'b1;
      c.imm  = w & 32'hFFFF_F000;
      ok = 1'b1;
    end else if (opc == 7'h03) begin
      c.sel = 4'd1; c.bsel = 1'b1; c.imm = 32'($signed(w[31:20])); ok = 1'b1;
    end else if (opc == 7'h23) begin
      c.sel = 4'd1; c.bsel = 1'b1;
      c.imm = 32'($signed({w[31:25], w[11:7]}));
      ok = 1'b1;
    end else if (opc == 7'h63) begin
      c.sel = BR_TAB[f3];
      ok = (f3 != 3'd2) && (f3 != 3'd3);
    end
    if (!ok) begin
      c = '0;
      c.illegal = 1'b1;
    end
    return c;
  endfunction

  function automatic logic exp_ready();
`ifdef ALU_CTRL_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || out_ready;
`endif
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  opcs [8];
    opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h00};
    w = $urandom;
    if ($urandom_range(0, 9) != 0) w[6:0] = opcs[$urandom_range(0, 6)];
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic v, input logic [31:0] w, input logic ordy);
    @(negedge clk);
    in_valid  = v;
    instr     = w;
    out_ready = ordy;
    #1;
  endtask

  // Advance the model across one rising edge.
  task automatic tick();
    logic acc, emit;
    ctl_t nw;
    acc  = in_valid && exp_ready();
    emit = (q.size() > 0) && out_ready;
    nw   = model(instr);
    @(posedge clk);
    if (emit) void'(q.pop_front());
    if (acc) q.push_back(nw);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; instr = '0; out_ready = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if ({out_valid, sel_alu, asel, bsel, imm, illegal} !== 40'b0) begin
      n_bad++;
      $display("FAIL reset_outputs got v=%0b sel=%h a=%0b b=%0b imm=%h ill=%0b want all 0",
               out_valid, sel_alu, asel, bsel, imm, illegal);
    end
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    drive(1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready got %0b want 1", in_ready);
    end
    tick();
  endtask

  task automatic test_directed();
    logic [31:0] vin [5];
    logic [3:0]  vsel [5];
    logic        vb [5];
    logic [31:0] vimm [5];
    logic        vill [5];
    vin  = '{32'h002081B3, 32'h402081B3, 32'h40335293, 32'h123450B7, 32'hFFFFFFFF};
    vsel = '{4'b0001, 4'b0010, 4'b1000, 4'b0000, 4'b0000};
    vb   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vimm = '{32'h0, 32'h0, 32'h3, 32'h12345000, 32'h0};
    vill = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, vin[i], 1'b1);
      tick();
      drive(1'b0, 32'h0, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b1 || sel_alu !== vsel[i] || bsel !== vb[i] || imm !== vimm[i] ||
          illegal !== vill[i] || asel !== 1'b0) begin
        n_bad++;
        $display("FAIL directed_%0d instr=%h got v=%0b sel=%b a=%0b b=%0b imm=%h ill=%0b want v=1 sel=%b a=0 b=%0b imm=%h ill=%0b",
                 i, vin[i], out_valid, sel_alu, asel, bsel, imm, illegal,
                 vsel[i], vb[i], vimm[i], vill[i]);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [31:0] words [4];
    int idx, emitted;
    logic v, ordy;
    words   = '{32'h00A00093, 32'h00308133, 32'hFFF00193, 32'h00112223};
    idx     = 0;
    emitted = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      v    = (idx < 4);
      ordy = !(cyc >= 1 && cyc < 4);
      drive(v, v ? words[idx] : 32'h0, ordy);
      n_cmp++;
      if (out_valid !== (q.size() > 0)) begin
        n_bad++;
        $display("FAIL stall_valid cyc=%0d got %0b want %0b", cyc, out_valid, q.size() > 0);
      end
      if (q.size() > 0) begin
        n_cmp++;
        if ({sel_alu, asel, bsel, imm, illegal} !== q[0]) begin
          n_bad++;
          $display("FAIL stall_data cyc=%0d got %h want %h", cyc,
                   {sel_alu, asel, bsel, imm, illegal}, q[0]);
        end
      end
      n_cmp++;
      if (in_ready !== exp_ready()) begin
        n_bad++;
        $display("FAIL stall_in_ready cyc=%0d got %0b want %0b", cyc, in_ready, exp_ready());
      end
      if (v && exp_ready()) idx++;
      if (q.size() > 0 && ordy) emitted++;
      tick();
    end
    n_cmp++;
    if (idx != 4 || emitted != 4) begin
      n_bad++;
      $display("FAIL stall_count got accepted=%0d emitted=%0d want 4/4", idx, emitted);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h002081B3, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_pre_valid got %0b want 1", out_valid);
    end
    #1 rst = 1'b1;
    #1;
    q.delete();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_async_valid got %0b want 0", out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL rstmid_post_%0d got v=%0b rdy=%0b want v=0 rdy=1", i, out_valid, in_ready);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic v, ordy;
    for (int cyc = 0; cyc < 400; cyc++) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = (cyc >= 380) || ($urandom_range(0, 9) < 7);
      drive(v && cyc < 380, rand_instr(), ordy);
      n_cmp++;
      if (out_valid !== (q.size() > 0)) begin
        n_bad++;
        $display("FAIL random_valid cyc=%0d got %0b want %0b", cyc, out_valid, q.size() > 0);
      end
      if (q.size() > 0) begin
        n_cmp++;
        if ({sel_alu, asel, bsel, imm, illegal} !== q[0]) begin
          n_bad++;
          $display("FAIL random_data cyc=%0d got %h want %h", cyc,
                   {sel_alu, asel, bsel, imm, illegal}, q[0]);
        end
      end
      n_cmp++;
      if (in_ready !== exp_ready()) begin
        n_bad++;
        $display("FAIL random_in_ready cyc=%0d got %0b want %0b", cyc, in_ready, exp_ready());
      end
      tick();
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL random_drain got %0d words pending want 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL: in_valid  input  1  instr is valid this cycle.
REQ-004 SHALL: in_ready  output  1  block accepts instr this cycle.
REQ-005 SHALL: instr  input  32  RV32I instruction word.
REQ-006 SHALL: out_valid  output  1  decoded control word is valid.
REQ-007 SHALL: out_ready  input  1  downstream accepts the control word.
REQ-008 SHALL: sel_alu  output  4  ALU op: IN2=0000, ADD=0001, SUB=0010, AND=0011, OR=0100, XOR=0101, SHL=0110, SHRL=0111, SHRA=1000, COMPU=1001, COMPS=1010.
REQ-009 SHALL: asel  output  1  operand A source: 0 = rs1, 1 = pc.
REQ-010 SHALL: bsel  output  1  operand B source: 0 = rs2, 1 = imm.
REQ-011 SHALL: imm  output  32  decoded immediate.
REQ-012 SHALL: illegal  output  1  instruction not decodable to an ALU op.

Function
REQ-013 SHALL: A transfer occurs on input when in_valid && in_ready, and on output when out_valid && out_ready.
REQ-014 SHALL: Latency is one cycle; an instruction accepted at edge N is presented with out_valid=1 after edge N.
REQ-015 SHALL: Output fields are held stable while out_valid=1 && out_ready=0.
REQ-016 SHALL: Transfers are delivered in order, with none dropped or duplicated.
REQ-017 SHALL: OP (0110011), funct7=0000000: funct3 000 ADD, 001 SHL, 010 COMPS, 011 COMPU, 100 XOR, 101 SHRL, 110 OR, 111 AND; bsel=0; imm=0.
REQ-018 SHALL: OP, funct7=0100000: funct3 000 SUB, 101 SHRA; every other funct7/funct3 combination is illegal.
REQ-019 SHALL: OP-IMM (0010011): funct3 mapping as REQ-017; bsel=1; imm = sign-extended I-immediate.
REQ-020 SHALL: OP-IMM funct3 001 requires funct7=0000000; funct3 101 with 0000000 gives SHRL and with 0100000 gives SHRA; shift imm = zero-extended instr[24:20]; any other funct7 is illegal.
REQ-021 SHALL: LUI (0110111) gives IN2, bsel=1, imm = {instr[31:12], 12'b0}; AUIPC (0010111) gives ADD, asel=1, bsel=1, same imm.
REQ-022 SHALL: LOAD (0000011) gives ADD, bsel=1 with I-immediate; STORE (0100011) gives ADD, bsel=1 with sign-extended S-immediate.
REQ-023 SHALL: BRANCH (1100011), bsel=0: funct3 000/001 SUB, 100/101 COMPS, 110/111 COMPU; 010/011 illegal.
REQ-024 SHALL: Any other opcode, or instr[1:0]!=11, is illegal.
REQ-025 SHALL: When illegal=1, the outputs are sel_alu=0000, asel=0, bsel=0, imm=0.
REQ-026 SHALL: asel=0 for every opcode except AUIPC.

Reset
REQ-027 SHALL: While rst=1, out_valid=0, sel_alu=0000, asel=0, bsel=0, imm=0, illegal=0, and the buffer is empty.
REQ-028 SHALL: Assertion of rst mid-transfer discards all held words; in_ready=1 on the first cycle after deassertion.

Configuration
REQ-029 SHALL: ALU_CTRL_SKID_EN defined: a 2-entry skid buffer is used; in_ready is a register output equal to "skid entry empty"; with the output stalled, one extra word is accepted and held; full throughput is sustained with out_ready=1.
REQ-030 SHALL: ALU_CTRL_SKID_EN undefined: a single output register is used; in_ready = !out_valid || out_ready (combinational).
REQ-031 SHALL: Decoded values and ordering are identical in both builds.

Verification
REQ-032 SHALL: instr=0x002081B3 (add), out_ready=1 -> next cycle sel_alu=0001, bsel=0, illegal=0.
REQ-033 SHALL: 0x402081B3 (sub) -> sel_alu=0010; 0x40335293 (srai 3) -> sel_alu=1000, bsel=1, imm=0x00000003.
REQ-034 SHALL: 0x123450B7 (lui) -> sel_alu=0000, bsel=1, imm=0x12345000; 0xFFFFFFFF -> illegal=1, sel_alu=0000, imm=0.
REQ-035 SHALL: Stream of 4 instructions with out_ready held low 3 cycles -> all 4 emitted in order; with SKID build, in_ready falls only after 2 words are held.
REQ-036 SHALL: rst pulse while out_valid=1 and out_ready=0 -> out_valid=0 immediately, held word never emitted, in_ready=1 after release.
